uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 73 +++++++
 rtl/uart.sv | 166 ++++++++++++++++
 tb/tb_uart.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared receiver state encoding and oversampling constants for the UART.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  // Oversampling ticks per bit time.
  localparam int OSR         = 16;
  // Tick count inside the start bit at which rx is re-checked (mid start bit).
  localparam int START_TICKS = 7;
  // Width of the per-bit tick counter (holds 0..OSR-1).
  localparam int TICK_W      = 4;

endpackage

// File: rtl/uart_fifo.sv
// Circular receive buffer, depth 2**FIFO_W, with wrapping read/write pointers.
// Latency: write visible next clock; r_data shows the oldest entry combinationally.
// Backpressure: a write to a full FIFO is dropped unless a read happens in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  logic            rd,
  input  logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] r_data,
  output logic            empty
);

  localparam int DEPTH = 2 ** FIFO_W;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wptr;
  logic [FIFO_W-1:0] rptr;
  logic [FIFO_W-1:0] wptr_nxt;
  logic [FIFO_W-1:0] rptr_nxt;
  logic              full;
  logic              wr_en;
  logic              rd_en;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // simultaneous write.
  assign rd_en    = rd & ~empty;
  assign wr_en    = wr & (~full | rd_en);
  assign wptr_nxt = wptr + 1'b1;
  assign rptr_nxt = rptr + 1'b1;
  assign r_data   = mem[rptr];

  // Storage array; no reset needed since empty/full gate every access.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= w_data;
    end
  end

  // Pointer and flag update; flags only move when exactly one side acts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          wptr  <= wptr_nxt;
          empty <= 1'b0;
          full  <= (wptr_nxt == rptr);
        end
        2'b01: begin
          rptr  <= rptr_nxt;
          full  <= 1'b0;
          empty <= (rptr_nxt == wptr);
        end
        2'b11: begin
          wptr <= wptr_nxt;
          rptr <= rptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// UART receiver: 16x oversampled serial input, FIFO-buffered bytes, registered rd_data.
// Latency: rx_done about 9.5 bit times after the start edge; pops show on rd_data next clock.
// Backpressure: none on rx; bytes arriving while the FIFO is full are dropped from the FIFO only.
module uart
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int DVSR   = 326,
  parameter int FIFO_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_uart,
  input  logic            rx,
  output logic [DBIT-1:0] rd_data,
  output logic            rx_done
);

  localparam int                CW        = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0]     CNT_MAX   = CW'(DVSR - 1);
  localparam int                NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0]     LAST_BIT  = NW'(DBIT - 1);
  localparam logic [TICK_W-1:0] START_MID = TICK_W'(START_TICKS);
  localparam logic [TICK_W-1:0] BIT_END   = TICK_W'(OSR - 1);

  logic [CW-1:0]     baud_cnt;
  logic              tick;
  logic              rx_meta;
  logic              rx_sync;
  rx_state_t         state_q, state_n;
  logic [TICK_W-1:0] s_q, s_n;
  logic [NW-1:0]     n_q, n_n;
  logic [DBIT-1:0]   b_q, b_n;
  logic              done_tick;
  logic [DBIT-1:0]   fifo_rdata;
  logic              fifo_empty;

  // Free-running oversampling tick generator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_MAX) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick = (baud_cnt == CNT_MAX);

  // Two-flop synchronizer on the asynchronous serial line; resets to idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      n_q     <= n_n;
      b_q     <= b_n;
    end
  end

  // Receiver next-state: find start edge, confirm mid start bit, sample each
  // data bit mid-bit (LSB first), then check the stop bit.
  always_comb begin
    state_n   = state_q;
    s_n       = s_q;
    n_n       = n_q;
    b_n       = b_q;
    done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == START_MID) begin
            if (!rx_sync) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              // Low pulse shorter than half a bit: treat as noise.
              state_n = IDLE;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == BIT_END) begin
            s_n = '0;
            b_n = {rx_sync, b_q[DBIT-1:1]};
            if (n_q == LAST_BIT) begin
              state_n = STOP;
            end else begin
              n_n = n_q + 1'b1;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == BIT_END) begin
            state_n = IDLE;
            // A low stop bit is a framing error: the byte is discarded.
            done_tick = rx_sync;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  uart_fifo #(
    .DBIT  (DBIT),
    .FIFO_W(FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (done_tick),
    .rd    (rd_uart),
    .w_data(b_q),
    .r_data(fifo_rdata),
    .empty (fifo_empty)
  );

  // Output register: a fresh frame wins over a pop; pops never pulse rx_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= done_tick;
      if (done_tick) begin
        rd_data <= b_q;
      end else if (rd_uart && !fifo_empty) begin
        rd_data <= fifo_rdata;
      end
    end
  end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: directed vector table, corner sequences, random frames vs a queue model.
// Latency: checks rx_done timing of the first frame against a 9..10 bit-time window.
// Backpressure: exercises FIFO overflow, empty pops and framing-error discard.
module tb_uart;

  localparam int DVSR   = 4;
  localparam int BITCLK = 16 * DVSR;
  localparam int DEPTH  = 4;

  localparam int OP_FRAME   = 0;
  localparam int OP_BADSTOP = 1;
  localparam int OP_GLITCH  = 2;
  localparam int OP_POP     = 3;

  typedef struct {
    int         op;
    logic [7:0] data;
    int         pulses;
    logic [7:0] rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_uart;
  logic       rx;
  logic [7:0] rd_data;
  logic       rx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pulse_cyc = 0;
  logic prev_done = 1'b0;
  logic [7:0] got_q[$];
  vec_t tbl[$];

  // Reference model: FIFO contents and the byte rd_data should hold.
  logic [7:0] mq[$];
  logic [7:0] m_rd;

  uart #(
    .DBIT  (8),
    .DVSR  (DVSR),
    .FIFO_W(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_uart(rd_uart),
    .rx     (rx),
    .rd_data(rd_data),
    .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rx_done === 1'b1) begin
      got_q.push_back(rd_data);
      pulse_cyc = cyc;
      check("rx_done_not_back_to_back", {31'd0, prev_done}, 32'd0);
    end
    prev_done = rx_done;
  end

  task automatic idle_bits(input int nbits);
    rx = 1'b1;
    repeat (nbits * BITCLK) @(negedge clk);
  endtask

  // Serial frame, LSB first. A bad stop bit is held low for 3/4 of a bit so
  // the receiver samples it low but sees high again before re-checking a start.
  task automatic send_frame(input logic [7:0] d, input bit good_stop, input int gap);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (good_stop) begin
      rx = 1'b1;
      repeat (BITCLK) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (12 * DVSR) @(negedge clk);
      rx = 1'b1;
      repeat (4 * DVSR) @(negedge clk);
    end
    idle_bits(gap);
  endtask

  task automatic send_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * DVSR) @(negedge clk);
    idle_bits(2);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic add(input int op, input logic [7:0] d, input int p, input logic [7:0] r);
    vec_t v;
    v.op = op;
    v.data = d;
    v.pulses = p;
    v.rd = r;
    tbl.push_back(v);
  endtask

  task automatic check_pulses(input string name, input int exp_n, input logic [7:0] exp_d);
    check({name, "_pulses"}, got_q.size(), exp_n);
    if (exp_n == 1 && got_q.size() >= 1) check({name, "_pulse_data"}, {24'd0, got_q[0]}, {24'd0, exp_d});
    got_q.delete();
  endtask

  initial begin
    int win;
    rst_n = 1'b0;
    rx = 1'b1;
    rd_uart = 1'b0;

    // Directed table: ten frames overflowing the FIFO, drains, glitch, framing error, ordered reads.
    add(OP_FRAME, 8'hAA, 1, 8'hAA);
    add(OP_FRAME, 8'h55, 1, 8'h55);
    add(OP_FRAME, 8'h01, 1, 8'h01);
    add(OP_FRAME, 8'hF0, 1, 8'hF0);
    add(OP_FRAME, 8'h0F, 1, 8'h0F);
    add(OP_FRAME, 8'hDE, 1, 8'hDE);
    add(OP_FRAME, 8'hAD, 1, 8'hAD);
    add(OP_FRAME, 8'hBE, 1, 8'hBE);
    add(OP_FRAME, 8'hEF, 1, 8'hEF);
    add(OP_FRAME, 8'hC0, 1, 8'hC0);
    add(OP_POP,   8'h00, 0, 8'hAA);
    add(OP_POP,   8'h00, 0, 8'h55);
    add(OP_POP,   8'h00, 0, 8'h01);
    add(OP_POP,   8'h00, 0, 8'hF0);
    add(OP_POP,   8'h00, 0, 8'hF0);
    add(OP_GLITCH, 8'h00, 0, 8'hF0);
    add(OP_BADSTOP, 8'h3C, 0, 8'hF0);
    add(OP_POP,   8'h00, 0, 8'hF0);
    add(OP_FRAME, 8'h11, 1, 8'h11);
    add(OP_FRAME, 8'h22, 1, 8'h22);
    add(OP_FRAME, 8'h33, 1, 8'h33);
    add(OP_POP,   8'h00, 0, 8'h11);
    add(OP_POP,   8'h00, 0, 8'h22);
    add(OP_POP,   8'h00, 0, 8'h33);
    add(OP_POP,   8'h00, 0, 8'h33);

    // Reset: 5 clocks low, outputs cleared, then quiet line produces no pulses.
    repeat (5) @(negedge clk);
    check("reset_rd_data", {24'd0, rd_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    check("idle_after_reset_pulses", got_q.size(), 0);
    got_q.delete();

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_FRAME:   send_frame(tbl[i].data, 1'b1, 5);
        OP_BADSTOP: send_frame(tbl[i].data, 1'b0, 5);
        OP_GLITCH:  send_glitch();
        default:    pop();
      endcase
      if (i == 0) begin
        win = pulse_cyc - start_cyc;
        check("first_frame_latency_in_window",
              {31'd0, (win >= 9 * BITCLK && win <= 10 * BITCLK)}, 32'd1);
      end
      check_pulses($sformatf("vec%0d", i), tbl[i].pulses, tbl[i].rd);
      check($sformatf("vec%0d_rd_data", i), {24'd0, rd_data}, {24'd0, tbl[i].rd});
    end

    // Reset in the middle of a frame: frame abandoned, outputs cleared, next frame clean.
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * BITCLK) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(12);
    check_pulses("midframe_reset", 0, 8'h00);
    check("midframe_reset_rd_data", {24'd0, rd_data}, 32'd0);
    pop();
    check("midframe_reset_fifo_empty", {24'd0, rd_data}, 32'd0);
    send_frame(8'h5A, 1'b1, 2);
    check_pulses("after_reset_frame", 1, 8'h5A);
    mq.delete();
    m_rd = 8'h5A;
    mq.push_back(8'h5A);

    // Random mix of frames, framing errors, glitches and pops against the queue model.
    for (int t = 0; t < 20; t++) begin
      int kind;
      logic [7:0] d;
      kind = $urandom_range(0, 9);
      d = 8'($urandom);
      if (kind < 7) begin
        send_frame(d, 1'b1, $urandom_range(1, 4));
        m_rd = d;
        if (mq.size() < DEPTH) mq.push_back(d);
        check_pulses($sformatf("rnd%0d_frame", t), 1, d);
      end else if (kind == 7) begin
        send_frame(d, 1'b0, $urandom_range(1, 4));
        check_pulses($sformatf("rnd%0d_badstop", t), 0, 8'h00);
      end else if (kind == 8) begin
        send_glitch();
        check_pulses($sformatf("rnd%0d_glitch", t), 0, 8'h00);
      end else begin
        int np;
        np = $urandom_range(1, 3);
        for (int k = 0; k < np; k++) begin
          pop();
          if (mq.size() > 0) m_rd = mq.pop_front();
        end
        check_pulses($sformatf("rnd%0d_pop", t), 0, 8'h00);
      end
      check($sformatf("rnd%0d_rd_data", t), {24'd0, rd_data}, {24'd0, m_rd});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
